school_rv_core: RTL and testbench
=================================

Name: school_rv_core

Overview:
- Single-cycle RV32I-subset CPU: one instruction fetched, decoded, executed and retired per clock.
- Fetches from an external combinational instruction ROM (sr_rom, SIZE words) through imAddr/imData.
- Exposes a debug read port into the register file; test programs report results in a0 (x10).

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imAddr  output  32  instruction memory word address = PC >> 2
- imData  input  32  instruction word at imAddr (combinational ROM read)
- regAddr  input  5  debug register index
- regData  output  32  debug register value; combinational read of x[regAddr]; 0 when regAddr = 0

Behaviour:
- State: 32-bit PC and a 31x32 register file (x1..x31). x0 reads 0; writes to x0 are discarded.
- Reset:
  - rst sampled high at a rising edge sets PC <= RESET_PC, so imAddr = 0 the cycle after.
  - Register contents are not cleared: a program must initialise them, and verification must not check register values before the program writes them.
  - rst asserted mid-program aborts the current instruction: no register write, PC reloaded.
- Cycle behaviour:
  - Each non-reset rising edge retires the instruction on imData.
  - The destination register is written at that edge and is visible on regData (combinational) immediately after.
  - PC update: PC <= PC+4, or PC + B-immediate for a taken branch.
- Supported instructions (RV32I encodings):
  - R-type (opcode 0110011): add, sub (funct7 0100000), or, and, xor, sll, srl, sltu.
  - I-type ALU (opcode 0010011): addi, andi, ori, xori, slli, srli, sltiu.
  - U-type (opcode 0110111): lui.
  - Branches (opcode 1100011): beq, bne.
- Arithmetic:
  - 32-bit modular; add/sub wrap without flags.
  - Shift amount is the low 5 bits of rs2 / shamt.
  - sltu/sltiu compare unsigned; the sltiu immediate is sign-extended first.
  - I immediates are sign-extended 12-bit.
  - lui writes imm[31:12] followed by 12 zero bits.
  - B immediate is sign-extended 13-bit with bit 0 = 0; PC wraps modulo 2^32.
- Any other opcode/funct combination executes as a NOP: PC+4, no register write. The core never halts.
- A register read in the same cycle as a write to that register returns the old value.
- imData containing X is not handled internally; the program must stay inside the initialised ROM.
- The core has no data memory, jumps or interrupts.

Decomposition:
- Package school_rv_pkg:
  - opcode constants (OP, OP_IMM, LUI, BRANCH)
  - funct3/funct7 constants
  - ALU operation enum
  - immediate-type enum
- Sub-modules:
  - school_rv_regfile: 2 read ports, 1 write port, plus the debug read port.
  - Decoder/control and ALU stay inside the core as combinational always blocks.

Test Plan:
- Reset: rst high 2 cycles, then low -> imAddr = 0 on the first post-reset cycle, then 1, 2, 3 on successive cycles for straight-line code; imData is never X.
- ALU smoke test:
  - Program: addi a0,x0,5; addi a1,x0,-3; add a0,a0,a1 -> regData(a0) = 5 then 2.
  - sub x0..; lui a0,0x12345 -> a0 = 0x12345000.
  - sltu a0,a1,a0 with a1 = 0xFFFFFFFD -> 0.
- Branch: beq taken with offset -8 -> imAddr decreases by 2. bne not taken -> imAddr+1. Loop executes the expected iteration count.
- x0 immutability: addi x0,x0,7 followed by add a0,x0,x0 -> a0 = 0. regAddr = 0 -> regData = 0.
- Fibonacci ROM (loop of add) -> a0 reaches 32'h00213d05 (fib(32)) within 1000 cycles after reset release.
- Factorial ROM (multiply by repeated add / shift-add) -> a0 reaches 32'h1c8cfc00 (12!) within 1000 cycles.
- Mid-run reset: assert rst for 1 cycle during the loop -> imAddr returns to 0 and the program reruns to the same result.

Source files
------------

// File: rtl/school_rv_pkg.sv
// school_rv_pkg: shared opcodes, funct fields and decode enums for school_rv_core.
package school_rv_pkg;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLTU, ALU_PASS
  } alu_op_e;
  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U, IMM_B} imm_e;
  // funct3 selects the same operation for register and immediate forms
  function automatic alu_op_e f3_alu(input logic [2:0] f3);
    case (f3)
      F3_SLL:  return ALU_SLL;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/school_rv_regfile.sv
// school_rv_regfile: x0..x31 register file, 2 read ports, 1 write port, 1 debug read port.
module school_rv_regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  daddr_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [31:0] ddata_o
);
  logic [31:0] regs_q [32];
  always_ff @(posedge clk) begin
    if (we_i && waddr_i != 5'd0) regs_q[waddr_i] <= wdata_i;
  end
  assign rdata1_o = raddr1_i == 5'd0 ? 32'd0 : regs_q[raddr1_i];
  assign rdata2_o = raddr2_i == 5'd0 ? 32'd0 : regs_q[raddr2_i];
  assign ddata_o  = daddr_i  == 5'd0 ? 32'd0 : regs_q[daddr_i];
endmodule

// File: rtl/school_rv_core.sv
// school_rv_core: single-cycle RV32I-subset core (ALU ops, lui, beq/bne), one instruction per clock.
module school_rv_core
  import school_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imAddr,
  input  logic [31:0] imData,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData
);
  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_u, imm_b, imm, rs1_data, rs2_data, op_b, alu_res;
  alu_op_e     alu_op;
  imm_e        imm_sel;
  logic        rd_we, is_br, taken;
  assign opcode = imData[6:0];
  assign rd     = imData[11:7];
  assign funct3 = imData[14:12];
  assign rs1    = imData[19:15];
  assign rs2    = imData[24:20];
  assign funct7 = imData[31:25];
  assign imm_i  = {{20{imData[31]}}, imData[31:20]};
  assign imm_u  = {imData[31:12], 12'd0};
  assign imm_b  = {{19{imData[31]}}, imData[31], imData[7], imData[30:25], imData[11:8], 1'b0};
  assign imm    = imm_sel == IMM_I ? imm_i : imm_sel == IMM_U ? imm_u : imm_b;
  assign op_b   = (imm_sel == IMM_I || imm_sel == IMM_U) ? imm : rs2_data;
  // Unsupported encodings leave rd_we/is_br low and fall through as NOPs
  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = IMM_NONE;
    rd_we   = 1'b0;
    is_br   = 1'b0;
    case (opcode)
      OP: begin
        alu_op = funct7 == F7_ALT ? ALU_SUB : f3_alu(funct3);
        rd_we  = (funct7 == F7_ALT && funct3 == F3_ADD) || (funct7 == F7_BASE && funct3 != F3_SLT);
      end
      OP_IMM: begin
        imm_sel = IMM_I;
        alu_op  = f3_alu(funct3);
        rd_we   = funct3 != F3_SLT && (!(funct3 == F3_SLL || funct3 == F3_SRL) || funct7 == F7_BASE);
      end
      LUI: begin
        imm_sel = IMM_U;
        alu_op  = ALU_PASS;
        rd_we   = 1'b1;
      end
      BRANCH: begin
        imm_sel = IMM_B;
        is_br   = funct3 == F3_BEQ || funct3 == F3_BNE;
      end
      default: ;
    endcase
  end
  always_comb begin
    alu_res = op_b;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_data + op_b;
      ALU_SUB:  alu_res = rs1_data - op_b;
      ALU_AND:  alu_res = rs1_data & op_b;
      ALU_OR:   alu_res = rs1_data | op_b;
      ALU_XOR:  alu_res = rs1_data ^ op_b;
      ALU_SLL:  alu_res = rs1_data << op_b[4:0];
      ALU_SRL:  alu_res = rs1_data >> op_b[4:0];
      ALU_SLTU: alu_res = {31'd0, rs1_data < op_b};
      default:  ;
    endcase
  end
  // funct3[0] distinguishes bne from beq
  assign taken  = is_br && ((rs1_data == rs2_data) ^ funct3[0]);
  assign pc_d   = taken ? pc_q + imm : pc_q + 32'd4;
  assign imAddr = {2'b00, pc_q[31:2]};
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  school_rv_regfile u_regfile (
    .clk      (clk),
    .we_i     (rd_we && !rst),
    .waddr_i  (rd),
    .wdata_i  (alu_res),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .daddr_i  (regAddr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .ddata_o  (regData)
  );
endmodule

// File: tb/tb_school_rv_core.sv
// tb_school_rv_core: directed programs with hand-computed register and fetch-address expectations.
module tb_school_rv_core;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0063;
  localparam logic [4:0] X0 = 5'd0, A0 = 5'd10, A1 = 5'd11, A2 = 5'd12, A3 = 5'd13, A4 = 5'd14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] regAddr = 5'd0;
  logic [31:0] imAddr, imData, regData;
  logic [31:0] rom [64];
  int errors = 0;
  int checks = 0;
  school_rv_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData), .regAddr(regAddr), .regData(regData)
  );
  always #5 clk = ~clk;
  assign imData = imAddr < 32'd64 ? rom[imAddr[5:0]] : NOP;
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(int imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    logic [31:0] t;
    t = imm;
    return {t[11:0], rs1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_b(int off, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    logic [31:0] t;
    t = off;
    return {t[12], t[10:5], rs2, rs1, f3, t[4:1], t[11], 7'b1100011};
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic peek(input logic [4:0] r, output logic [31:0] v);
    regAddr = r;
    #1;
    v = regData;
  endtask
  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask
  task automatic load_fib();
    clear_rom();
    rom[0] = enc_i(0, X0, 3'b000, A0);
    rom[1] = enc_i(1, X0, 3'b000, A1);
    rom[2] = enc_i(32, X0, 3'b000, A2);
    rom[3] = enc_r(7'd0, A1, A0, 3'b000, A3);
    rom[4] = enc_i(0, A1, 3'b000, A0);
    rom[5] = enc_i(0, A3, 3'b000, A1);
    rom[6] = enc_i(-1, A2, 3'b000, A2);
    rom[7] = enc_b(-16, X0, A2, 3'b001);
    rom[8] = HALT;
  endtask
  task automatic test_reset();
    clear_rom();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imAddr !== 32'(i) || $isunknown(imData)) begin
        errors++;
        $display("FAIL reset_fetch[%0d]: imAddr=%h imData=%h, expected imAddr=%h and known imData", i, imAddr, imData, 32'(i));
      end
      step();
    end
  endtask
  task automatic test_alu_smoke();
    logic [31:0] prog [6];
    logic [4:0] rr [6];
    logic [31:0] ev [6];
    logic [31:0] v;
    prog = '{enc_i(5, X0, 3'b000, A0), enc_i(-3, X0, 3'b000, A1), enc_r(7'd0, A1, A0, 3'b000, A0),
             enc_r(7'b0100000, A1, A0, 3'b000, X0), enc_u(20'h12345, A0), enc_r(7'd0, A0, A1, 3'b011, A0)};
    rr = '{A0, A1, A0, X0, A0, A0};
    ev = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'h1234_5000, 32'd0};
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = prog[i];
    rom[6] = HALT;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      peek(rr[i], v);
      checks++;
      if (v !== ev[i] || imAddr !== 32'(i + 1)) begin
        errors++;
        $display("FAIL alu_smoke[%0d]: x%0d=%h imAddr=%h, expected %h imAddr=%h", i, rr[i], v, imAddr, ev[i], 32'(i + 1));
      end
    end
  endtask
  task automatic test_alu_ops();
    logic [31:0] prog [22];
    logic [4:0] rr [22];
    logic [31:0] ev [22];
    logic [31:0] v;
    prog = '{enc_i(32'h5A5, X0, 3'b000, A1), enc_i(-256, X0, 3'b000, A2), enc_i(36, X0, 3'b000, A3),
             enc_r(7'd0, A2, A1, 3'b100, A0), enc_r(7'd0, A2, A1, 3'b110, A0), enc_r(7'd0, A2, A1, 3'b111, A0),
             enc_r(7'd0, A3, A1, 3'b001, A0), enc_r(7'd0, A3, A2, 3'b101, A0), enc_r(7'd0, A2, A1, 3'b011, A0),
             enc_r(7'b0100000, A2, A1, 3'b000, A0), enc_i(32'h7F0, A2, 3'b111, A0), enc_i(-1, A1, 3'b110, A0),
             enc_i(-1, A2, 3'b100, A0), enc_i(20, A1, 3'b001, A0), enc_i(8, A2, 3'b101, A0),
             enc_i(-1, A2, 3'b011, A0), enc_i(5, A2, 3'b011, A0), enc_r(7'd0, A2, A2, 3'b000, A0),
             32'hFFFF_FFFF, enc_r(7'd0, A2, A1, 3'b010, A0), enc_i(32'h404, A2, 3'b101, A0),
             enc_r(7'b0100000, A3, A2, 3'b101, A0)};
    rr = '{A1, A2, A3, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0, A0};
    ev = '{32'h0000_05A5, 32'hFFFF_FF00, 32'h0000_0024, 32'hFFFF_FAA5, 32'hFFFF_FFA5, 32'h0000_0500,
           32'h0000_5A50, 32'h0FFF_FFF0, 32'h0000_0001, 32'h0000_06A5, 32'h0000_0700, 32'hFFFF_FFFF,
           32'h0000_00FF, 32'h5A50_0000, 32'h00FF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FE00,
           32'hFFFF_FE00, 32'hFFFF_FE00, 32'hFFFF_FE00, 32'hFFFF_FE00};
    clear_rom();
    for (int i = 0; i < 22; i++) rom[i] = prog[i];
    rom[22] = HALT;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step();
      peek(rr[i], v);
      checks++;
      if (v !== ev[i] || imAddr !== 32'(i + 1)) begin
        errors++;
        $display("FAIL alu_ops[%0d]: x%0d=%h imAddr=%h, expected %h imAddr=%h", i, rr[i], v, imAddr, ev[i], 32'(i + 1));
      end
    end
  endtask
  task automatic test_branch();
    int seq [15];
    logic [31:0] v;
    seq = '{1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5, 6, 4, 5, 6};
    clear_rom();
    rom[0] = enc_i(0, X0, 3'b000, A0);
    rom[1] = enc_i(3, X0, 3'b000, A1);
    rom[2] = enc_i(1, A0, 3'b000, A0);
    rom[3] = enc_i(-1, A1, 3'b000, A1);
    rom[4] = enc_b(-8, X0, A1, 3'b001);
    rom[5] = enc_b(8, A1, A0, 3'b000);
    rom[6] = enc_b(-8, X0, X0, 3'b000);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (imAddr !== 32'(seq[i])) begin
        errors++;
        $display("FAIL branch_pc[%0d]: imAddr=%h expected %h", i, imAddr, 32'(seq[i]));
      end
    end
    peek(A0, v);
    checks++;
    if (v !== 32'd3) begin
      errors++;
      $display("FAIL branch_iterations: a0=%h expected %h", v, 32'd3);
    end
  endtask
  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = enc_b(-4, X0, X0, 3'b000);
    do_reset();
    step();
    checks++;
    if (imAddr !== 32'h3FFF_FFFF) begin
      errors++;
      $display("FAIL pc_wrap_back: imAddr=%h expected %h", imAddr, 32'h3FFF_FFFF);
    end
    step();
    checks++;
    if (imAddr !== 32'd0) begin
      errors++;
      $display("FAIL pc_wrap_fwd: imAddr=%h expected %h", imAddr, 32'd0);
    end
  endtask
  task automatic test_x0();
    logic [31:0] v;
    clear_rom();
    rom[0] = enc_i(9, X0, 3'b000, A0);
    rom[1] = enc_i(7, X0, 3'b000, X0);
    rom[2] = enc_r(7'd0, X0, X0, 3'b000, A0);
    rom[3] = HALT;
    do_reset();
    step();
    peek(A0, v);
    checks++;
    if (v !== 32'd9) begin
      errors++;
      $display("FAIL x0_setup: a0=%h expected %h", v, 32'd9);
    end
    step();
    peek(X0, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: x0=%h expected %h", v, 32'd0);
    end
    step();
    peek(A0, v);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL x0_read: a0=%h expected %h", v, 32'd0);
    end
  endtask
  task automatic test_fibonacci();
    int n;
    logic [31:0] v;
    load_fib();
    do_reset();
    n = 0;
    while (imAddr !== 32'd8 && n < 1000) begin
      step();
      n++;
    end
    peek(A0, v);
    checks++;
    if (n >= 1000 || v !== 32'h0021_3D05) begin
      errors++;
      $display("FAIL fib: a0=%h after %0d cycles, expected %h within 1000", v, n, 32'h0021_3D05);
    end
  endtask
  task automatic test_factorial();
    int n;
    logic [31:0] v;
    clear_rom();
    rom[0]  = enc_i(1, X0, 3'b000, A0);
    rom[1]  = enc_i(2, X0, 3'b000, A1);
    rom[2]  = enc_i(13, X0, 3'b000, A4);
    rom[3]  = enc_i(0, X0, 3'b000, A2);
    rom[4]  = enc_i(0, A1, 3'b000, A3);
    rom[5]  = enc_r(7'd0, A0, A2, 3'b000, A2);
    rom[6]  = enc_i(-1, A3, 3'b000, A3);
    rom[7]  = enc_b(-8, X0, A3, 3'b001);
    rom[8]  = enc_i(0, A2, 3'b000, A0);
    rom[9]  = enc_i(1, A1, 3'b000, A1);
    rom[10] = enc_b(-28, A4, A1, 3'b001);
    rom[11] = HALT;
    do_reset();
    n = 0;
    while (imAddr !== 32'd11 && n < 1000) begin
      step();
      n++;
    end
    peek(A0, v);
    checks++;
    if (n >= 1000 || v !== 32'h1C8C_FC00) begin
      errors++;
      $display("FAIL factorial: a0=%h after %0d cycles, expected %h within 1000", v, n, 32'h1C8C_FC00);
    end
  endtask
  task automatic test_mid_reset();
    int n;
    int seen;
    logic [31:0] v;
    load_fib();
    do_reset();
    n = 0;
    seen = 0;
    while (seen < 3 && n < 100) begin
      step();
      n++;
      if (imAddr === 32'd4) seen++;
    end
    checks++;
    if (seen < 3) begin
      errors++;
      $display("FAIL mid_reset_reach: visits=%0d expected 3", seen);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    peek(A0, v);
    checks++;
    if (imAddr !== 32'd0 || v !== 32'd1) begin
      errors++;
      $display("FAIL mid_reset_abort: imAddr=%h a0=%h, expected imAddr=0 a0=%h", imAddr, v, 32'd1);
    end
    n = 0;
    while (imAddr !== 32'd8 && n < 1000) begin
      step();
      n++;
    end
    peek(A0, v);
    checks++;
    if (n >= 1000 || v !== 32'h0021_3D05) begin
      errors++;
      $display("FAIL mid_reset_rerun: a0=%h after %0d cycles, expected %h", v, n, 32'h0021_3D05);
    end
  endtask
  initial begin
    clear_rom();
    test_reset();
    test_alu_smoke();
    test_alu_ops();
    test_branch();
    test_pc_wrap();
    test_x0();
    test_fibonacci();
    test_factorial();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
